regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port (RegWrite/Rd/Wr_data) between two writeback sources:
- A: the in-order pipeline writeback stage.
- B: the multi-cycle unit (loads/mul/div).

B results are queued in a small FIFO. A has priority, with a starvation limit that forces B through. A 32-bit busy scoreboard tracks registers with outstanding B results, which the hazard unit uses for stalls.

---
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between pipeline writeback (A) and queued multi-cycle results (B)
// Ports: clk/rst; A request a_valid/a_rd/a_data -> a_ready; B result b_valid/b_rd/b_data -> b_ready;
//        issue_valid/issue_rd mark pending B destinations; RegWrite/Rd/Wr_data registered write port; busy scoreboard
module regfile_wb_arbiter #(
    parameter int B_FIFO_DEPTH = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        RegWrite,
    output logic [4:0]  Rd,
    output logic [31:0] Wr_data,
    output logic [31:0] busy
);
    localparam int PW = (B_FIFO_DEPTH > 1) ? $clog2(B_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(B_FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(B_FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]    rd_mem_q   [B_FIFO_DEPTH];
    logic [31:0]   data_mem_q [B_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          regwrite_q, regwrite_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic [31:0]   busy_q, busy_d;
    logic          empty, full, force_b, grant_a, grant_b, push;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;

    assign empty     = count_q == '0;
    assign full      = count_q == DEPTH_C;
    assign force_b   = (starve_q == LIMIT_C) && !empty;
    assign a_ready   = !force_b && !rst;
    assign b_ready   = !full && !rst;
    assign grant_a   = !rst && !force_b && a_valid;
    assign grant_b   = !rst && (force_b || (!a_valid && !empty));
    assign push      = b_valid && b_ready;
    assign head_rd   = rd_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];

    assign count_d   = count_q + CW'(push) - CW'(grant_b);
    // The counter only measures losses while something is actually waiting.
    assign starve_d  = (empty || grant_b) ? '0 : (starve_q == LIMIT_C) ? starve_q : starve_q + 1'b1;
    // x0 grants still consume the entry but never write.
    assign regwrite_d = grant_a ? (a_rd != 5'd0) : grant_b ? (head_rd != 5'd0) : 1'b0;
    assign rd_d       = grant_a ? a_rd : grant_b ? head_rd : rd_q;
    assign wr_data_d  = grant_a ? a_data : grant_b ? head_data : wr_data_q;

    // Clear is applied before set so an issue to the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (grant_b) busy_d[head_rd] = 1'b0;
        if (issue_valid) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[wr_ptr_q]   <= b_rd;
            data_mem_q[wr_ptr_q] <= b_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wr_data_q  <= '0;
            busy_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + PW'(push);
            rd_ptr_q   <= rd_ptr_q + PW'(grant_b);
            count_q    <= count_d;
            starve_q   <= starve_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    assign RegWrite = regwrite_q;
    assign Rd       = rd_q;
    assign Wr_data  = wr_data_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  a_rd = '0, b_rd = '0, issue_rd = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, RegWrite;
    logic [4:0]  Rd;
    logic [31:0] Wr_data, busy;

    regfile_wb_arbiter #(.B_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .RegWrite(RegWrite), .Rd(Rd), .Wr_data(Wr_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] busy;
    } exp_t;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } bent_t;

    exp_t        exp_q[$];
    bent_t       bq[$];
    int          starve = 0;
    logic [31:0] m_busy = '0;
    int          edge_cnt = 0;
    int          checks = 0;
    int          passed = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    // Monitor: every cycle that has a pending expectation is compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
                e = exp_q.pop_front();
                check("sb_due", e.due, edge_cnt);
            end
            if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                e = exp_q.pop_front();
                check("RegWrite", RegWrite, e.we);
                if (e.we) begin
                    check("Rd", Rd, e.rd);
                    check("Wr_data", Wr_data, e.data);
                end
                check("busy", busy, e.busy);
            end
        end
    end

    // One cycle of stimulus; the reference model predicts the grant and next-cycle outputs.
    task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                        input logic iv, input logic [4:0] ird);
        exp_t  e;
        bent_t h;
        bit    fb, ga, gb;
        int    n;
        @(negedge clk);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        issue_valid = iv; issue_rd = ird;
        #1;
        n  = bq.size();
        fb = (starve == LIMIT) && (n > 0);
        check("a_ready", a_ready, !fb);
        check("b_ready", b_ready, n < DEPTH);
        ga = !fb && av;
        gb = fb || (!av && n > 0);
        e.due = edge_cnt + 1; e.we = 0; e.rd = 0; e.data = 0;
        if (ga) begin
            e.we = ard != 0; e.rd = ard; e.data = ad;
        end else if (gb) begin
            h = bq.pop_front();
            e.we = h.rd != 0; e.rd = h.rd; e.data = h.data;
            m_busy[h.rd] = 1'b0;
        end
        if (iv && ird != 0) m_busy[ird] = 1'b1;
        m_busy[0] = 1'b0;
        e.busy = m_busy;
        starve = (n == 0 || gb) ? 0 : (starve < LIMIT ? starve + 1 : LIMIT);
        if (bv && n < DEPTH) begin
            h.rd = brd; h.data = bd;
            bq.push_back(h);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_steps(input int n);
        logic [4:0] ar;
        for (int i = 0; i < n; i++) begin
            ar = 5'($urandom_range(0, 31));
            if (m_busy[ar]) ar = 0;
            step(1'($urandom), ar, $urandom, 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
        end
    endtask

    task automatic reset_mid();
        @(negedge clk);
        a_valid = 0; b_valid = 0; issue_valid = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_RegWrite", RegWrite, 0);
        check("rst_busy", busy, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_a_ready", a_ready, 0);
        exp_q.delete();
        bq.delete();
        starve = 0;
        m_busy = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_RegWrite", RegWrite, 0);
        check("reset_Rd", Rd, 0);
        check("reset_Wr_data", Wr_data, 0);
        check("reset_busy", busy, 0);
        check("reset_a_ready", a_ready, 0);
        check("reset_b_ready", b_ready, 0);
        rst = 1'b0;
        idle(10);
        step(1, 5, 32'h12345678, 0, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 1, 10);
        step(0, 0, 0, 1, 10, 32'hDEADBEEF, 0, 0);
        idle(3);
        step(1, 1, 32'h11, 1, 7, 32'h77, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 5'(2 + i), 32'h100 + i, 0, 0, 0, 0, 0);
        step(1, 3, 32'h33, 1, 0, 32'hBAD0, 1, 0);
        step(1, 4, 32'h44, 1, 9, 32'h99, 0, 0);
        step(1, 5, 32'h55, 1, 12, 32'hCC, 0, 0);
        idle(6);
        rand_steps(400);
        idle(4);
        step(0, 0, 0, 0, 0, 0, 1, 10);
        step(1, 1, 32'hA1, 1, 3, 32'h333, 0, 0);
        step(1, 2, 32'hA2, 1, 4, 32'h444, 0, 0);
        reset_mid();
        idle(8);
        rand_steps(150);
        idle(6);
        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
